// File: rtl/mic_spi_capture_pkg.sv
// Shared FSM encoding, frame geometry and the sample-magnitude helper for the mic capture block.
// Pure declarations: no logic, no latency.
package mic_spi_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int          FRAME_BITS = 16;
   localparam logic [11:0] MIDSCALE   = 12'd2048;

   // Only the zero sample reaches 2048; clamp it so the result fits 11 bits.
   function automatic logic [10:0] sample_mag(input logic [11:0] s);
      logic [11:0] d;
      d = (s >= MIDSCALE) ? (s - MIDSCALE) : (MIDSCALE - s);
      return d[11] ? 11'h7FF : d[10:0];
   endfunction

endpackage

// File: rtl/mic_sclk_gen.sv
// Half-period timer: strobes every SCLK_HALF cycles while run_i is high, alternating fall/rise.
// First strobe after run_i rises is a fall, SCLK_HALF cycles later; no backpressure.
module mic_sclk_gen #(
   parameter int SCLK_HALF = 5
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run_i,
   output logic fall_o,
   output logic rise_o
);

   localparam int CW = $clog2(SCLK_HALF + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          strobe;

   assign strobe = run_i && (cnt_q == CW'(SCLK_HALF - 1));
   assign fall_o = strobe && !phase_q;
   assign rise_o = strobe && phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!run_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (strobe) begin
         cnt_d   = '0;
         phase_d = !phase_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/mic_spi_capture.sv
// Periodic 16-bit SPI read of a mic ADC, 12-bit sample output plus windowed peak-deviation hold.
// sample_valid lands 33*SCLK_HALF cycles after mic_cs_n falls; ticks seen mid-frame are dropped.
module mic_spi_capture
   import mic_spi_capture_pkg::*;
#(
   parameter int SCLK_HALF   = 5,
   parameter int SAMPLE_DIV  = 5000,
   parameter int PEAK_WINDOW = 2000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        mic_miso,
   output logic        mic_cs_n,
   output logic        mic_sclk,
   output logic [11:0] sample,
   output logic        sample_valid,
   output logic        frame_err,
   output logic [10:0] peak
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int WW = $clog2(PEAK_WINDOW + 1);
   localparam int BW = $clog2(FRAME_BITS + 1);

   if (SAMPLE_DIV <= 34 * SCLK_HALF + 2 || SCLK_HALF < 1) begin : g_param_check
      $error("mic_spi_capture: SAMPLE_DIV too small for one frame, or SCLK_HALF < 1");
   end

   state_e                  state_q, state_d;
   logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
   logic                    cs_n_q, cs_n_d, sclk_q, sclk_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [11:0]             sample_q, sample_d;
   logic                    err_q, err_d, valid_q, valid_d;
   logic [10:0]             run_max_q, run_max_d, peak_q, peak_d, mag, max_now;
   logic [WW-1:0]           win_cnt_q, win_cnt_d;
   logic                    tick, sclk_fall, sclk_rise;

   mic_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
      .clock  (clock),
      .reset_n(reset_n),
      .run_i  (state_q != ST_IDLE),
      .fall_o (sclk_fall),
      .rise_o (sclk_rise)
   );

   assign tick       = (tick_cnt_q == '0);
   assign tick_cnt_d = (tick_cnt_q == TW'(SAMPLE_DIV - 1)) ? '0 : tick_cnt_q + TW'(1);

   always_comb begin
      state_d   = state_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      sample_d  = sample_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (tick && enable) begin
            state_d   = ST_SETUP;
            cs_n_d    = 1'b0;
            bit_cnt_d = '0;
         end
         ST_SETUP: if (sclk_fall) begin
            state_d = ST_SHIFT;
            sclk_d  = 1'b0;
         end
         ST_SHIFT: if (sclk_rise) begin
            sclk_d    = 1'b1;
            shreg_d   = {shreg_q[FRAME_BITS-2:0], mic_miso};
            bit_cnt_d = bit_cnt_q + BW'(1);
         end else if (sclk_fall) begin
            // The fall slot after the last rise closes the frame instead of clocking again.
            if (bit_cnt_q == BW'(FRAME_BITS)) begin
               state_d  = ST_DONE;
               cs_n_d   = 1'b1;
               sample_d = shreg_q[11:0];
               err_d    = |shreg_q[15:12];
               valid_d  = 1'b1;
            end else begin
               sclk_d = 1'b0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign mag     = sample_mag(sample_q);
   assign max_now = (mag > run_max_q) ? mag : run_max_q;

   always_comb begin
      run_max_d = run_max_q;
      peak_d    = peak_q;
      win_cnt_d = win_cnt_q;
      if (valid_q) begin
         if (win_cnt_q == WW'(PEAK_WINDOW - 1)) begin
            peak_d    = max_now;
            run_max_d = '0;
            win_cnt_d = '0;
         end else begin
            run_max_d = max_now;
            win_cnt_d = win_cnt_q + WW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b1;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         sample_q   <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         run_max_q  <= '0;
         peak_q     <= '0;
         win_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         sample_q   <= sample_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         run_max_q  <= run_max_d;
         peak_q     <= peak_d;
         win_cnt_q  <= win_cnt_d;
      end
   end

   assign mic_cs_n     = cs_n_q;
   assign mic_sclk     = sclk_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign frame_err    = err_q;
   assign peak         = peak_q;

endmodule

// File: tb/tb_mic_spi_capture.sv
// Bench for mic_spi_capture: ADC MISO model, scoreboard of expected samples/peaks, SPI framing monitor.
module tb_mic_spi_capture;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic        mic_miso = 1'b0;
   logic        mic_cs_n, mic_sclk, sample_valid, frame_err;
   logic [11:0] sample;
   logic [10:0] peak;

   int checks = 0;
   int failures = 0;

   logic [15:0] miso_word = 16'h0000;
   int          bit_idx = 15;
   logic [12:0] exp_q[$];
   logic [10:0] exp_peak_q[$];

   int   cyc = 0, cs_fall_cyc = 0, cs_falls = 0, rises = 0, win_cnt = 0, sclk_viol = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b1, peak_pend = 1'b0;

   mic_spi_capture #(
      .SCLK_HALF  (5),
      .SAMPLE_DIV (200),
      .PEAK_WINDOW(4)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .mic_miso    (mic_miso),
      .mic_cs_n    (mic_cs_n),
      .mic_sclk    (mic_sclk),
      .sample      (sample),
      .sample_valid(sample_valid),
      .frame_err   (frame_err),
      .peak        (peak)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ADC model: presents the next bit MSB-first on each falling mic_sclk.
   always @(negedge mic_cs_n) bit_idx = 15;
   always @(negedge mic_sclk) begin
      if (!mic_cs_n && bit_idx >= 0) begin
         mic_miso = miso_word[bit_idx];
         bit_idx--;
      end
   end

   // Monitor: scoreboard pops on sample_valid, framing checks on mic_cs_n/mic_sclk.
   always @(negedge clock) begin
      if (!reset_n) begin
         win_cnt   = 0;
         peak_pend = 1'b0;
         rises     = 0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b1;
      end else begin
         if (peak_pend) begin
            peak_pend = 1'b0;
            if (exp_peak_q.size() == 0) check("peak_unexpected", 1, 0);
            else check("peak", peak, exp_peak_q.pop_front());
         end
         if (mic_cs_n && !mic_sclk) sclk_viol++;
         if (prev_cs && !mic_cs_n) begin
            cs_fall_cyc = cyc;
            cs_falls++;
            rises = 0;
         end
         if (!mic_cs_n && mic_sclk && !prev_sclk) rises++;
         if (!prev_cs && mic_cs_n) check("sclk_rises_per_frame", rises, 16);
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               logic [12:0] e;
               e = exp_q.pop_front();
               check("sample", sample, e[11:0]);
               check("frame_err", frame_err, e[12]);
            end
            check("valid_latency", cyc - cs_fall_cyc, 165);
            win_cnt++;
            if (win_cnt == 4) begin
               win_cnt   = 0;
               peak_pend = 1'b1;
            end
         end
         prev_cs   = mic_cs_n;
         prev_sclk = mic_sclk;
      end
   end

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 600 && !seen; k++) begin
         @(negedge clock);
         seen = sample_valid;
      end
      check({name, "_valid_timeout"}, seen, 1);
   endtask

   task automatic wait_cs_fall(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 600 && !seen; k++) begin
         @(negedge clock);
         seen = !mic_cs_n;
      end
      check({name, "_cs_timeout"}, seen, 1);
   endtask

   initial begin
      logic [15:0] pw[8];
      int          nfalls;
      pw = '{16'h0800, 16'h0BB8, 16'h0064, 16'h09C4,
             16'h0800, 16'h0800, 16'h0800, 16'h0800};

      #2 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_cs_n", mic_cs_n, 1);
      check("rst_sclk", mic_sclk, 1);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_peak", peak, 0);

      // Frame A: clean sample, tick fires on the first edge after release.
      miso_word = 16'h0A5A;
      exp_q.push_back({1'b0, 12'hA5A});
      enable = 1'b1;
      @(negedge clock) reset_n = 1'b1;
      wait_valid("frameA");
      repeat (10) @(negedge clock);
      check("hold_sample", sample, 12'hA5A);

      // Frame B: non-zero leading bits flag an error.
      miso_word = 16'h8001;
      exp_q.push_back({1'b1, 12'h001});
      wait_valid("frameB");

      // Frame C: enable drops mid-frame, frame still completes, next tick ignored.
      miso_word = 16'h0800;
      exp_q.push_back({1'b0, 12'h800});
      wait_cs_fall("frameC");
      repeat (40) @(posedge clock);
      enable = 1'b0;
      wait_valid("frameC");
      nfalls = cs_falls;
      repeat (250) @(negedge clock);
      check("no_start_disabled", cs_falls, nfalls);
      check("cs_idle_disabled", mic_cs_n, 1);

      // Frame D: reset mid-frame abandons it.
      miso_word = 16'h0123;
      enable = 1'b1;
      wait_cs_fall("frameD");
      repeat (80) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_cs_n", mic_cs_n, 1);
      check("midrst_sclk", mic_sclk, 1);
      check("midrst_sample", sample, 0);
      check("midrst_valid", sample_valid, 0);
      miso_word = pw[0];
      exp_peak_q.push_back(11'd1948);
      exp_peak_q.push_back(11'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      #1 check("start_after_rst", mic_cs_n, 0);

      // Peak windows: 2048,3000,100,2500 then four midscale samples.
      for (int i = 0; i < 8; i++) begin
         miso_word = pw[i];
         exp_q.push_back({1'b0, pw[i][11:0]});
         wait_valid("peak_frame");
      end
      repeat (3) @(negedge clock);

      check("sample_queue_drained", exp_q.size(), 0);
      check("peak_queue_drained", exp_peak_q.size(), 0);
      check("sclk_high_when_cs_high", sclk_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mic_spi_capture.md
MIC_SPI_CAPTURE -- requirements
Module: mic_spi_capture

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 5, meaning clock cycles per mic_sclk half-period (10 MHz at 100 MHz clock).
REQ-002 SHALL have parameter SAMPLE_DIV, default 5000, meaning clock cycles between frame starts (20 kHz sample rate).
REQ-003 SHALL have parameter PEAK_WINDOW, default 2000, meaning samples per peak-hold window.
REQ-004 SHALL have port clock, input, 1, system clock (100 MHz).
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, allows new frames to start.
REQ-007 SHALL have port mic_miso, input, 1, serial data from the microphone ADC (JXADC3).
REQ-008 SHALL have port mic_cs_n, output, 1, ADC chip select, active low (JXADC1).
REQ-009 SHALL have port mic_sclk, output, 1, ADC serial clock, idles high (JXADC4).
REQ-010 SHALL have port sample, output, 12, last captured unsigned sample.
REQ-011 SHALL have port sample_valid, output, 1, one-cycle pulse when sample updates.
REQ-012 SHALL have port frame_err, output, 1, high when the last frame's 4 leading bits were not all zero.
REQ-013 SHALL have port peak, output, 11, max |sample-2048| over the last completed window.

Function
REQ-014 SHALL run a free sample-tick counter 0..SAMPLE_DIV-1; the tick fires at count 0.
REQ-015 SHALL use FSM states IDLE, SETUP, SHIFT, DONE.
REQ-016 IDLE -> SETUP on tick with enable=1; mic_cs_n falls at that edge (T0).
REQ-017 mic_sclk SHALL fall at T0+H and toggle every H cycles (H=SCLK_HALF), giving 16 falling/rising pairs.
REQ-018 mic_miso SHALL be sampled on each mic_sclk rising edge, MSB first; bit k sampled at T0+2H*(16-k).
REQ-019 After the 16th rising edge, SHIFT -> DONE; at T0+33H mic_cs_n SHALL rise, sample SHALL load bits[11:0], frame_err SHALL load (bits[15:12]!=0), and sample_valid SHALL pulse one cycle.
REQ-020 DONE -> IDLE next cycle; mic_sclk SHALL remain high whenever mic_cs_n is high.
REQ-021 A tick arriving while not IDLE SHALL be ignored, with no queueing.
REQ-022 Deasserting enable mid-frame SHALL NOT abort the frame; the current frame completes.
REQ-023 Magnitude SHALL be sample>=2048 ? sample-2048 : 2048-sample, computed at 12 bits and truncated to 11; 2048-0 saturates to 2047.
REQ-024 A running max SHALL update on each sample_valid; after PEAK_WINDOW samples, peak SHALL take the running max (including the current sample) and the running max SHALL restart from 0.
REQ-025 sample and peak SHALL hold their values between updates.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, mic_cs_n=1, mic_sclk=1, sample=0, sample_valid=0, frame_err=0, peak=0, and clear all counters and the shift register.
REQ-027 Reset mid-frame SHALL abandon the frame with no sample_valid; the first tick after release starts at counter 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the frame bit count (16), and the midscale constant (2048).
REQ-029 One sub-module, mic_sclk_gen (half-period enable counter producing fall/rise strobes), is natural.
REQ-030 Elaboration SHALL fail if SAMPLE_DIV <= 34*SCLK_HALF+2 or SCLK_HALF < 1.

Verification
REQ-031 MISO model drives 0000_1010_0101_1010, enable=1 -> sample=0xA5A, frame_err=0, valid at T0+165 cycles (H=5).
REQ-032 MISO drives 1000_0000_0000_0001 -> sample=0x001, frame_err=1.
REQ-033 enable drops at T0+40 -> the frame completes; no mic_cs_n fall at the next tick.
REQ-034 reset_n pulsed low at T0+80 -> mic_cs_n=1 and mic_sclk=1 immediately, no sample_valid, sample=0.
REQ-035 PEAK_WINDOW=4 with samples 2048, 3000, 100, 2500 -> peak=1948 after the 4th valid; the next window with all 2048 -> peak=0.
REQ-036 Check every frame: exactly 16 mic_sclk rising edges while mic_cs_n=0, and mic_sclk high whenever mic_cs_n=1.
